// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer and its
// forwarding units.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_FLUSH = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [4:0] REG_X0 = 5'd0;

  // x0 is hardwired to zero, so it can never be a real producer/consumer pair.
  function automatic logic reg_match(input logic en, input logic [4:0] src,
                                     input logic [4:0] dst);
    return en && (src == dst) && (src != REG_X0);
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// Operand forwarding select for one EX source register; MEM result beats WB data.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ex_addr,
  input  logic [4:0] mem_addr_d,
  input  logic       mem_regwen,
  input  logic [4:0] wb_addr_d,
  input  logic       wb_regwen,
  output logic [1:0] fwd_sel
);

  always_comb begin
    fwd_sel = FWD_RF;
    if (reg_match(mem_regwen, ex_addr, mem_addr_d)) begin
      fwd_sel = FWD_MEM;
    end else if (reg_match(wb_regwen, ex_addr, wb_addr_d)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding sequencer for the 5-stage RV32I pipeline.
// Defining HAZ_PERF_CNT_EN adds the stall_cnt / flush_cnt performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  id_addr_a,
  input  logic [4:0]  id_addr_b,
  input  logic        id_uses_a,
  input  logic        id_uses_b,
  input  logic [4:0]  ex_addr_a,
  input  logic [4:0]  ex_addr_b,
  input  logic [4:0]  ex_addr_d,
  input  logic        ex_regwen,
  input  logic        ex_is_load,
  input  logic        ex_pcsel,
  input  logic [4:0]  mem_addr_d,
  input  logic        mem_regwen,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic [4:0]  wb_addr_d,
  input  logic        wb_regwen,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        idex_we,
  output logic        exmem_we,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        mem_timeout_err
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam logic [3:0] FLUSH_RELOAD   = 4'(FLUSH_CYCLES - 1);
  localparam logic [8:0] TIMEOUT_LIMIT  = 9'(MEM_TIMEOUT);
  localparam logic       INSTANT_TMO    = (MEM_TIMEOUT <= 1);

  state_t      state;
  state_t      next_state;
  logic [3:0]  flush_left;
  logic [3:0]  next_flush;
  logic [7:0]  wait_cnt;
  logic [7:0]  next_wait;
  logic        err_set;

  logic        mem_busy;
  logic        first_tmo;
  logic        mem_stall;
  logic        load_use;
  logic [8:0]  wait_inc;
  logic        wait_tmo;

  logic        pc_we_c;
  logic        ifid_we_c;
  logic        idex_we_c;
  logic        exmem_we_c;
  logic        ifid_flush_c;
  logic        idex_flush_c;
  logic [1:0]  fwd_a_raw;
  logic [1:0]  fwd_b_raw;

  pipe_fwd_unit u_fwd_a (
    .ex_addr    (ex_addr_a),
    .mem_addr_d (mem_addr_d),
    .mem_regwen (mem_regwen),
    .wb_addr_d  (wb_addr_d),
    .wb_regwen  (wb_regwen),
    .fwd_sel    (fwd_a_raw)
  );

  pipe_fwd_unit u_fwd_b (
    .ex_addr    (ex_addr_b),
    .mem_addr_d (mem_addr_d),
    .mem_regwen (mem_regwen),
    .wb_addr_d  (wb_addr_d),
    .wb_regwen  (wb_regwen),
    .fwd_sel    (fwd_b_raw)
  );

  // A one-cycle timeout budget means the very first wait cycle already expires.
  always_comb begin
    mem_busy  = mem_req && !mem_ready;
    first_tmo = mem_busy && INSTANT_TMO;
    mem_stall = mem_busy && !INSTANT_TMO;
    load_use  = ex_is_load && ex_regwen &&
                (reg_match(id_uses_a, id_addr_a, ex_addr_d) ||
                 reg_match(id_uses_b, id_addr_b, ex_addr_d));
    wait_inc  = {1'b0, wait_cnt} + 9'd1;
    wait_tmo  = !mem_ready && (wait_inc >= TIMEOUT_LIMIT);
  end

  always_comb begin
    next_state   = state;
    next_flush   = flush_left;
    next_wait    = wait_cnt;
    err_set      = 1'b0;
    pc_we_c      = 1'b1;
    ifid_we_c    = 1'b1;
    idex_we_c    = 1'b1;
    exmem_we_c   = 1'b1;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;

    case (state)
      RUN: begin
        if (mem_stall) begin
          {pc_we_c, ifid_we_c, idex_we_c, exmem_we_c} = 4'b0000;
          next_wait  = 8'd1;
          next_state = MEM_WAIT;
        end else begin
          err_set = first_tmo;
          if (ex_pcsel) begin
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              next_flush = FLUSH_RELOAD;
              next_state = BR_FLUSH;
            end
          end else if (load_use) begin
            pc_we_c      = 1'b0;
            ifid_we_c    = 1'b0;
            idex_flush_c = 1'b1;
          end
        end
      end

      // The flush count is left untouched while memory stalls, so it resumes later.
      BR_FLUSH: begin
        if (mem_stall) begin
          {pc_we_c, ifid_we_c, idex_we_c, exmem_we_c} = 4'b0000;
          next_wait  = 8'd1;
          next_state = MEM_WAIT;
        end else begin
          err_set      = first_tmo;
          ifid_flush_c = 1'b1;
          if (ex_pcsel) begin
            idex_flush_c = 1'b1;
            next_flush   = FLUSH_RELOAD;
          end else if (flush_left <= 4'd1) begin
            next_flush = 4'd0;
            next_state = RUN;
          end else begin
            next_flush = flush_left - 4'd1;
          end
        end
      end

      MEM_WAIT: begin
        if (mem_ready || wait_tmo) begin
          err_set    = !mem_ready;
          next_wait  = 8'd0;
          next_state = (flush_left != 4'd0) ? BR_FLUSH : RUN;
        end else begin
          {pc_we_c, ifid_we_c, idex_we_c, exmem_we_c} = 4'b0000;
          next_wait = wait_inc[7:0];
        end
      end

      default: begin
        next_state = RUN;
        next_flush = 4'd0;
        next_wait  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= RUN;
      flush_left      <= 4'd0;
      wait_cnt        <= 8'd0;
      mem_timeout_err <= 1'b0;
    end else begin
      state      <= next_state;
      flush_left <= next_flush;
      wait_cnt   <= next_wait;
      if (err_set) begin
        mem_timeout_err <= 1'b1;
      end
    end
  end

  // Hold the whole pipeline quiet while reset is asserted.
  always_comb begin
    pc_we      = reset_n && pc_we_c;
    ifid_we    = reset_n && ifid_we_c;
    idex_we    = reset_n && idex_we_c;
    exmem_we   = reset_n && exmem_we_c;
    ifid_flush = reset_n && ifid_flush_c;
    idex_flush = reset_n && idex_flush_c;
    fwd_a_sel  = reset_n ? fwd_a_raw : FWD_RF;
    fwd_b_sel  = reset_n ? fwd_b_raw : FWD_RF;
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (!pc_we) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (ifid_flush) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
